interval_timer_ctrl: RTL and testbench

Programmable interval timer controller that sequences one embedded N-bit up-counter (synchronous enable, async active-low clear, +1 per enabled cycle, modulo 2^N). It arms the counter against a modular compare target, raises an interrupt request on each expiry in one-shot or periodic mode, and tracks missed acknowledges. It sits between the configuration/control logic and the core interrupt handler.

---
 rtl/interval_timer_ctrl.sv | 139 +++++++++++++
 tb/tb_interval_timer_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl
//   Programmable interval timer. Sequences an embedded N-bit up-counter.
//   Each time the counter reaches a modular compare target, the timer raises
//   an interrupt request. It runs in one-shot or periodic mode, and it
//   records an expiry that lands while an earlier irq is still pending.
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   cfg_load/period/mode    configuration latch (accepted in IDLE only)
//   start, stop, irq_ack    control pulses
//   irq, overrun            interrupt request (level) and sticky missed-ack flag
//   busy, done, count       state == RUN, state == DONE, counter value

module itc_up_counter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    output logic [N-1:0] count
);
    // Counts up by one on each enabled cycle and wraps modulo 2^N.
    // Only reset_n clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else if (en)  count <= count + 1'b1;
    end
endmodule

module interval_timer_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cfg_load,
    input  logic [N-1:0] cfg_period,
    input  logic         cfg_mode,
    input  logic         start,
    input  logic         stop,
    input  logic         irq_ack,
    output logic         irq,
    output logic         overrun,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] count
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] period_q, period_d;
    logic [N-1:0] target_q, target_d;
    logic         mode_q, mode_d;
    logic         irq_d, overrun_d;
    logic         match, match_eff, cnt_en;

    itc_up_counter #(.N(N)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (cnt_en),
        .count   (count)
    );

    assign match     = (state_q == RUN) && (count == target_q);
    // A stop in the same cycle discards the expiry entirely.
    assign match_eff = match && !stop;
    // One-shot freezes the counter on the target. Stop halts the counter in the same cycle.
    assign cnt_en    = (state_q == RUN) && !(match && !mode_q) && !stop;

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        mode_d    = mode_q;
        target_d  = target_q;
        irq_d     = irq;
        overrun_d = overrun;

        case (state_q)
            IDLE: begin
                if (!stop) begin
                    if (cfg_load) begin
                        period_d = cfg_period;
                        mode_d   = cfg_mode;
                    end
                    // An arm request uses the period latched before this cycle.
                    if (start && period_q != '0) begin
                        state_d  = RUN;
                        target_d = count + period_q;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (match) begin
                    if (mode_q) target_d = target_q + period_q;
                    else        state_d  = DONE;
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d  = RUN;
                    target_d = count + period_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new expiry wins over an acknowledge for irq. The acknowledge
        // still clears overrun, so a coincident ack plus match leaves
        // irq = 1 and overrun = 0.
        if (match_eff)    irq_d = 1'b1;
        else if (irq_ack) irq_d = 1'b0;

        if (irq_ack)                 overrun_d = 1'b0;
        else if (match_eff && irq)   overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            period_q <= '0;
            mode_q   <= 1'b0;
            target_q <= '0;
            irq      <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            irq      <= irq_d;
            overrun  <= overrun_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_interval_timer_ctrl.sv
module tb_interval_timer_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_load = 1'b0;
    logic [31:0] cfg_period = '0;
    logic        cfg_mode = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        irq_ack = 1'b0;

    logic        irq, overrun, busy, done;
    logic [31:0] count;
    logic        irq8, overrun8, busy8, done8;
    logic [7:0]  count8;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    interval_timer_ctrl #(.N(32)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_period(cfg_period),
        .cfg_mode(cfg_mode), .start(start), .stop(stop), .irq_ack(irq_ack),
        .irq(irq), .overrun(overrun), .busy(busy), .done(done), .count(count)
    );

    // The 8-bit instance shares the stimulus. It is checked only in the wrap-around case.
    interval_timer_ctrl #(.N(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_period(cfg_period[7:0]),
        .cfg_mode(cfg_mode), .start(start), .stop(stop), .irq_ack(irq_ack),
        .irq(irq8), .overrun(overrun8), .busy(busy8), .done(done8), .count(count8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge. All drives and samples happen there.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic configure(input logic [31:0] p, input logic m);
        cfg_load = 1'b1; cfg_period = p; cfg_mode = m;
        tick(1);
        cfg_load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        // ---- reset state
        do_reset();
        chk("rst_irq", irq, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);

        // ---- one-shot, P=5, starting from count 0
        configure(5, 0);
        pulse_start();                 // edge t0
        chk("os_busy_t0", busy, 1);
        chk("os_count_t0", count, 0);
        tick(5);                       // t5: count 5, match cycle follows
        chk("os_count_t5", count, 5);
        chk("os_irq_t5", irq, 0);
        tick(1);                       // t6
        chk("os_irq_t6", irq, 1);
        chk("os_done_t6", done, 1);
        chk("os_busy_t6", busy, 0);
        chk("os_count_t6", count, 5);
        tick(3);
        chk("os_count_hold", count, 5);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("os_irq_ack", irq, 0);

        // ---- periodic, P=3, acknowledge every irq
        do_reset();
        configure(3, 1);
        pulse_start();
        tick(3);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("per_count_m%0d", k), count, 3 * k);
            chk($sformatf("per_irq_pre%0d", k), irq, 0);
            tick(1);
            chk($sformatf("per_irq%0d", k), irq, 1);
            chk($sformatf("per_ovr%0d", k), overrun, 0);
            irq_ack = 1'b1;
            tick(1);
            irq_ack = 1'b0;
            chk($sformatf("per_ack%0d", k), irq, 0);
            tick(1);
        end

        // ---- overrun, P=2 periodic, no ack
        do_reset();
        configure(2, 1);
        pulse_start();
        tick(3);                       // count 3, after first match
        chk("ovr_irq1", irq, 1);
        chk("ovr_ovr1", overrun, 0);
        tick(2);                       // count 5, after second match
        chk("ovr_count5", count, 5);
        chk("ovr_ovr2", overrun, 1);
        chk("ovr_irq2", irq, 1);
        irq_ack = 1'b1;
        tick(1);                       // count 6
        irq_ack = 1'b0;
        chk("ovr_ack_irq", irq, 0);
        chk("ovr_ack_ovr", overrun, 0);
        tick(1);                       // count 7, irq from the match at 6
        chk("ovr_irq3", irq, 1);
        tick(2);                       // count 9, overrun from the match at 8
        chk("ovr_ovr3", overrun, 1);
        tick(1);                       // count 10: match cycle
        irq_ack = 1'b1;
        tick(1);                       // ack coincident with the match
        irq_ack = 1'b0;
        chk("ovr_coinc_irq", irq, 1);
        chk("ovr_coinc_ovr", overrun, 0);

        // ---- wrap-around on the 8-bit instance
        do_reset();
        configure(250, 0);
        pulse_start();
        tick(251);
        chk("wrap_pre_count", count8, 250);
        chk("wrap_pre_done", done8, 1);
        irq_ack = 1'b1; stop = 1'b1;
        tick(1);
        irq_ack = 1'b0; stop = 1'b0;
        configure(10, 1);
        pulse_start();                 // target = 250 + 10 = 4 (mod 256)
        tick(6);
        chk("wrap_count0", count8, 0);
        tick(1);
        chk("wrap_no_irq_at0", irq8, 0);
        tick(3);
        chk("wrap_count4", count8, 4);
        tick(1);
        chk("wrap_irq1", irq8, 1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("wrap_ack", irq8, 0);
        tick(8);
        chk("wrap_count14", count8, 14);
        chk("wrap_irq_pre2", irq8, 0);
        tick(1);
        chk("wrap_irq2", irq8, 1);
        chk("wrap_ovr", overrun8, 0);

        // ---- priority: stop during a match cycle
        do_reset();
        configure(4, 1);
        pulse_start();
        tick(4);                       // count 4, match cycle
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("pri_stop_irq", irq, 0);
        chk("pri_stop_busy", busy, 0);
        chk("pri_stop_count", count, 4);
        tick(2);
        chk("pri_stop_hold", count, 4);
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        chk("pri_startstop", busy, 0);
        configure(0, 0);
        pulse_start();
        chk("pri_p0_busy", busy, 0);

        // ---- asynchronous reset mid-RUN
        do_reset();
        configure(5, 1);
        pulse_start();
        tick(11);                      // count 11: matches at 5 and 10, no ack
        chk("ar_pre_busy", busy, 1);
        chk("ar_pre_ovr", overrun, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_irq", irq, 0);
        chk("ar_ovr", overrun, 0);
        chk("ar_busy", busy, 0);
        chk("ar_count", count, 0);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        pulse_start();
        chk("ar_start_ignored", busy, 0);
        tick(1);
        chk("ar_count_idle", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
